// File: rtl/tdm_pkg.sv
// Shared definitions for the 2-channel TDM link (transmit mux and receive demux).
package tdm_pkg;

    localparam int unsigned TDM_DATA_W  = 8;
    localparam int unsigned TDM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_A = 2'd1,
        EXP_B = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_idle_timer.sv
// Clearable idle-cycle counter; at_limit_o is high while the count sits at TIMEOUT-1,
// so the next idle cycle is the one that times out.
module tdm_idle_timer
    import tdm_pkg::*;
#(
    parameter int unsigned TIMEOUT = TDM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam int unsigned         CNT_W = 8;
    localparam logic [CNT_W-1:0]    LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= (cnt_d == LIMIT);
        end
    end

    assign at_limit_o = at_limit_q;

endmodule

// File: rtl/tdm_demux8bit1to2.sv
// Receive side of the 2-channel TDM link: frame-lock FSM, A/B capture registers.
// Optional frame/error counters are built when TDM_DEMUX_STATS_EN is defined.
module tdm_demux8bit1to2
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W  = TDM_DATA_W,
    parameter int unsigned TIMEOUT = TDM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_sync,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic              locked,
    output logic              sync_err
`ifdef TDM_DEMUX_STATS_EN
    ,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
`endif
);

    tdm_state_e        state_q;
    logic [DATA_W-1:0] a_data_q, b_data_q;
    logic              a_valid_q, b_valid_q, locked_q, sync_err_q;
    logic              idle_c, expire_c, at_limit;

    // The counter only runs while locked and the link is quiet.
    assign idle_c   = (state_q != HUNT) && !din_valid;
    assign expire_c = idle_c && at_limit;

    tdm_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (!idle_c || at_limit),
        .inc_i      (idle_c),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            a_data_q   <= '0;
            b_data_q   <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (din_valid && din_sync) begin
                        a_data_q  <= din;
                        a_valid_q <= 1'b1;
                        state_q   <= EXP_B;
                        locked_q  <= 1'b1;
                    end
                end
                EXP_B: begin
                    if (din_valid && !din_sync) begin
                        b_data_q  <= din;
                        b_valid_q <= 1'b1;
                        state_q   <= EXP_A;
                    end else if (din_valid) begin
                        // A sync word here restarts the frame rather than dropping lock.
                        sync_err_q <= 1'b1;
                        a_data_q   <= din;
                        a_valid_q  <= 1'b1;
                    end else if (expire_c) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                end
                EXP_A: begin
                    if (din_valid && din_sync) begin
                        a_data_q  <= din;
                        a_valid_q <= 1'b1;
                        state_q   <= EXP_B;
                    end else if (din_valid) begin
                        sync_err_q <= 1'b1;
                        state_q    <= HUNT;
                        locked_q   <= 1'b0;
                    end else if (expire_c) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign a_data   = a_data_q;
    assign b_data   = b_data_q;
    assign a_valid  = a_valid_q;
    assign b_valid  = b_valid_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;

`ifdef TDM_DEMUX_STATS_EN
    logic       b_take_c, err_c;
    logic [7:0] frame_cnt_q, err_cnt_q;

    assign b_take_c = (state_q == EXP_B) && din_valid && !din_sync;
    assign err_c    = din_valid && (((state_q == EXP_B) && din_sync) ||
                                    ((state_q == EXP_A) && !din_sync));

    // Counters advance on the same edge that raises the matching pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (b_take_c) frame_cnt_q <= frame_cnt_q + 8'(1);
            if (err_c)    err_cnt_q   <= err_cnt_q + 8'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux8bit1to2.sv
// Bench for tdm_demux8bit1to2: directed vector table, timeout/reset sequences,
// then random traffic against a frame-level reference model.
module tb_tdm_demux8bit1to2;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid, din_sync;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, locked, sync_err;
`ifdef TDM_DEMUX_STATS_EN
    logic [7:0] frame_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    tdm_demux8bit1to2 #(
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sync  (din_sync),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .locked    (locked),
        .sync_err  (sync_err)
`ifdef TDM_DEMUX_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: "locked" plus "an A word is waiting for its B partner".
    bit         m_lock, m_have_a, m_av, m_bv, m_err;
    int         m_idle, m_frames, m_errs;
    logic [7:0] m_a, m_b;

    task automatic model_reset();
        m_lock = 0; m_have_a = 0; m_av = 0; m_bv = 0; m_err = 0;
        m_idle = 0; m_frames = 0; m_errs = 0; m_a = 8'h00; m_b = 8'h00;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] d);
        m_av = 0; m_bv = 0; m_err = 0;
        if (v) begin
            m_idle = 0;
            if (s) begin
                if (m_lock && m_have_a) m_err = 1;
                m_a = d; m_av = 1; m_lock = 1; m_have_a = 1;
            end else if (m_lock) begin
                if (m_have_a) begin
                    m_b = d; m_bv = 1; m_have_a = 0;
                end else begin
                    m_err = 1; m_lock = 0;
                end
            end
        end else if (m_lock) begin
            m_idle++;
            if (m_idle == int'(TIMEOUT)) begin
                m_lock = 0; m_idle = 0;
            end
        end
        if (m_bv)  m_frames++;
        if (m_err) m_errs++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".a_valid"},  32'(a_valid),  32'(m_av));
        chk({tag, ".b_valid"},  32'(b_valid),  32'(m_bv));
        chk({tag, ".a_data"},   32'(a_data),   32'(m_a));
        chk({tag, ".b_data"},   32'(b_data),   32'(m_b));
        chk({tag, ".locked"},   32'(locked),   32'(m_lock));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
`ifdef TDM_DEMUX_STATS_EN
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(8'(m_frames)));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(8'(m_errs)));
`endif
    endtask

    // Drive at negedge, step the model at posedge, outputs are sampled 1ns later.
    task automatic drive(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        din_valid = v; din_sync = s; din = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
    endtask

    typedef struct {
        bit         v, s;
        logic [7:0] d;
        bit         av, bv;
        logic [7:0] a, b;
        bit         lk, er;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // v  s  din    av bv a      b      lk er
        tbl[0]  = '{1, 1, 8'hA5, 1, 0, 8'hA5, 8'h00, 1, 0};
        tbl[1]  = '{1, 0, 8'h3C, 0, 1, 8'hA5, 8'h3C, 1, 0};
        tbl[2]  = '{0, 0, 8'h00, 0, 0, 8'hA5, 8'h3C, 1, 0};
        tbl[3]  = '{1, 0, 8'h77, 0, 0, 8'hA5, 8'h3C, 0, 1};
        tbl[4]  = '{1, 0, 8'h11, 0, 0, 8'hA5, 8'h3C, 0, 0};
        tbl[5]  = '{1, 0, 8'h11, 0, 0, 8'hA5, 8'h3C, 0, 0};
        tbl[6]  = '{1, 0, 8'h11, 0, 0, 8'hA5, 8'h3C, 0, 0};
        tbl[7]  = '{1, 1, 8'h22, 1, 0, 8'h22, 8'h3C, 1, 0};
        tbl[8]  = '{1, 1, 8'h55, 1, 0, 8'h55, 8'h3C, 1, 1};
        tbl[9]  = '{1, 0, 8'h66, 0, 1, 8'h55, 8'h66, 1, 0};
        tbl[10] = '{1, 1, 8'h99, 1, 0, 8'h99, 8'h66, 1, 0};

        rst = 1'b1; din = 8'h00; din_valid = 1'b0; din_sync = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_model("reset");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            string t;
            drive(tbl[i].v, tbl[i].s, tbl[i].d);
            t = $sformatf("vec%0d", i);
            chk({t, ".a_valid"},  32'(a_valid),  32'(tbl[i].av));
            chk({t, ".b_valid"},  32'(b_valid),  32'(tbl[i].bv));
            chk({t, ".a_data"},   32'(a_data),   32'(tbl[i].a));
            chk({t, ".b_data"},   32'(b_data),   32'(tbl[i].b));
            chk({t, ".locked"},   32'(locked),   32'(tbl[i].lk));
            chk({t, ".sync_err"}, 32'(sync_err), 32'(tbl[i].er));
        end

        // 15 idle cycles then a valid word: lock must survive.
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 8'h00);
            chk($sformatf("idle15.c%0d.locked", k), 32'(locked), 32'd1);
        end
        drive(1, 0, 8'h12);
        chk("idle15.b_valid", 32'(b_valid), 32'd1);
        chk("idle15.b_data",  32'(b_data),  32'h12);
        chk("idle15.locked",  32'(locked),  32'd1);

        // After an A word, exactly TIMEOUT idle cycles drop lock silently.
        drive(1, 1, 8'h34);
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            drive(0, 0, 8'h00);
            chk($sformatf("idle16.c%0d.locked", k),   32'(locked),   (k < int'(TIMEOUT)) ? 32'd1 : 32'd0);
            chk($sformatf("idle16.c%0d.sync_err", k), 32'(sync_err), 32'd0);
        end
        compare_model("timeout");

        // Async reset between an A word and its B word.
        drive(1, 1, 8'hC3);
        compare_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.a_data",  32'(a_data),  32'h0);
        chk("async_rst.a_valid", 32'(a_valid), 32'd0);
        chk("async_rst.locked",  32'(locked),  32'd0);
        compare_model("async_rst");
        @(negedge clk); @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b0;
        drive(1, 0, 8'hEE);
        compare_model("post_rst_nosync");

        // 256 clean frames (wraps the frame counter when stats are built in).
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 8'(i));
            compare_model("frames.a");
            drive(1, 0, ~8'(i));
            compare_model("frames.b");
        end

        // Random traffic with occasional long idle bursts.
        for (int i = 0, burst = 0; i < 3000; i++) begin
            bit v, s;
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(10, 20);
            if (burst > 0) begin
                burst--;
                v = 0;
            end else begin
                v = ($urandom_range(0, 9) < 8);
            end
            s = ($urandom_range(0, 1) == 1);
            drive(v, s, 8'($urandom));
            compare_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
